// File: rtl/demux_scan_pkg.sv
// Shared types and constants for the round-robin demux scanner.
package demux_scan_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Everything the scanner presents to the demux in one cycle.
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             demux_in;
    logic [N_CH-1:0]  ack;
  } drive_t;

  function automatic logic [N_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
    ch_onehot = N_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set bit at or above i_start, wrapping.
module rr_pick8
  import demux_scan_pkg::*;
(
  input  logic [N_CH-1:0]  i_pending,
  input  logic [SEL_W-1:0] i_start,
  output logic             o_valid_c,
  output logic [SEL_W-1:0] o_idx_c
);

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    o_valid_c = 1'b0;
    o_idx_c   = i_start;
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if (i_pending[i_start + SEL_W'(k)]) begin
        o_valid_c = 1'b1;
        o_idx_c   = i_start + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Round-robin channel scanner driving sel/demux_in of a 1-to-8 demux switch,
// with a fixed dwell per service, one-cycle ack and a guard gap afterwards.
module demux_scan_ctrl
  import demux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_flush,
  input  logic [N_CH-1:0]  i_req,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_demux_in,
  output logic [N_CH-1:0]  o_ack,
  output logic             o_busy,
  output logic [N_CH-1:0]  o_pending
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP == 0) ? '0 : CNT_W'(GAP - 1);
  localparam bit               HAS_GAP    = (GAP != 0);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N_CH-1:0]  r_pending;
  logic [N_CH-1:0]  w_pending_nxt;
  logic [N_CH-1:0]  w_clr;
  logic [SEL_W-1:0] r_last;
  logic [SEL_W-1:0] w_last_nxt;
  drive_t           r_drv;
  drive_t           w_drv_nxt;
  logic             r_busy;

  logic [SEL_W-1:0] w_start;
  logic             w_pick_valid;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_cnt_zero;
  logic             w_start_svc;

  // Search begins one past the channel serviced last.
  assign w_start = r_last + SEL_W'(1);

  rr_pick8 u_pick (
    .i_pending (r_pending),
    .i_start   (w_start),
    .o_valid_c (w_pick_valid),
    .o_idx_c   (w_pick_idx)
  );

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_start_svc = i_enable & w_pick_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_svc) begin
            w_state_nxt = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (w_cnt_zero) begin
            w_state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (w_cnt_zero) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of the drive bundle, counter, clear mask and last pointer.
  always_comb begin
    w_drv_nxt     = r_drv;
    w_drv_nxt.ack = '0;
    w_cnt_nxt     = r_cnt;
    w_clr         = '0;
    w_last_nxt    = r_last;
    if (i_flush) begin
      w_drv_nxt.demux_in = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_drv_nxt.demux_in = 1'b0;
          if (w_start_svc) begin
            w_drv_nxt.sel      = w_pick_idx;
            w_drv_nxt.demux_in = 1'b1;
            w_cnt_nxt          = DWELL_LOAD;
          end
        end
        ST_DRIVE: begin
          if (w_cnt_zero) begin
            w_drv_nxt.demux_in = 1'b0;
            w_drv_nxt.ack      = ch_onehot(r_drv.sel);
            w_clr              = ch_onehot(r_drv.sel);
            w_last_nxt         = r_drv.sel;
            w_cnt_nxt          = GAP_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          w_drv_nxt.demux_in = 1'b0;
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: w_drv_nxt.demux_in = 1'b0;
      endcase
    end
  end

  // A new request on the clearing edge wins, so the channel is queued again.
  assign w_pending_nxt = i_flush ? '0 : ((r_pending & ~w_clr) | i_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drv     <= '0;
      r_cnt     <= '0;
      r_pending <= '0;
      r_last    <= SEL_W'(N_CH - 1);
      r_busy    <= 1'b0;
    end else begin
      r_drv     <= w_drv_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_last    <= w_last_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_sel      = r_drv.sel;
  assign o_demux_in = r_drv.demux_in;
  assign o_ack      = r_drv.ack;
  assign o_busy     = r_busy;
  assign o_pending  = r_pending;

  // Glitch-freedom invariants seen by the downstream demux.
  a_sel_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (o_demux_in && $past(o_demux_in)) |-> $stable(o_sel));
  a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(o_ack));
  a_ack_gap    : assert property (@(posedge clk) disable iff (!rst_n)
    (o_ack != '0) |-> !o_demux_in);
  a_drive_busy : assert property (@(posedge clk) disable iff (!rst_n)
    o_demux_in |-> o_busy);

endmodule
